// File: rtl/mem_resp.sv
// mem_resp: data-memory responder for the SISC core.
// The control FSM raises req_rd or req_wr and holds it until ack is seen.
// ack rises LAT edges after the accept edge. The internal word RAM is not
// cleared by reset. Every output is driven from a register.
module mem_resp #(
    parameter int DW  = 32,
    parameter int AW  = 8,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          req_rd,
    input  logic          req_wr,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    logic [3:0]    cnt_r;
    logic          op_wr_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r;
    logic          ack_r;
    logic [DW-1:0] rdata_r;
    logic          busy_r;
    logic          err_r;

    logic          req_active_s;
    logic          we_s;
    logic [AW-1:0] wa_s;
    logic [DW-1:0] wd_s;

    logic [DW-1:0] mem_r [0:(2**AW)-1];

    assign ack   = ack_r;
    assign rdata = rdata_r;
    assign busy  = busy_r;
    assign err   = err_r;

    // The request line that belongs to the access currently in flight.
    always_comb begin
        req_active_s = 1'b0;
        if (op_wr_r) begin
            req_active_s = req_wr;
        end else begin
            req_active_s = req_rd;
        end
    end

    // RAM write port: fires on the edge that enters RESP for a write.
    always_comb begin
        we_s = 1'b0;
        wa_s = addr_r;
        wd_s = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if ((LAT == 0) && req_wr && !req_rd) begin
                    we_s = 1'b1;
                    wa_s = req_addr;
                    wd_s = req_wdata;
                end else begin
                    we_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (op_wr_r && req_wr && (cnt_r == 4'd1)) begin
                    we_s = 1'b1;
                end else begin
                    we_s = 1'b0;
                end
            end
            default: we_s = 1'b0;
        endcase
    end

    // RAM storage; no reset, and no write while reset is asserted.
    always_ff @(posedge clk) begin
        if (we_s && rst_f) begin
            mem_r[wa_s] <= wd_s;
        end
    end

    // Handshake FSM with registered ack/busy/err/rdata.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            op_wr_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            ack_r   <= 1'b0;
            rdata_r <= '0;
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_rd && req_wr) begin
                        err_r <= 1'b1;
                    end else if (req_rd || req_wr) begin
                        op_wr_r <= req_wr;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        if (LAT == 0) begin
                            state_r <= ST_RESP;
                            ack_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            if (!req_wr) begin
                                rdata_r <= mem_r[req_addr];
                            end
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= 4'(LAT);
                            busy_r  <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!req_active_s) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 4'd0;
                    end else if (cnt_r == 4'd1) begin
                        state_r <= ST_RESP;
                        ack_r   <= 1'b1;
                        busy_r  <= 1'b0;
                        cnt_r   <= 4'd0;
                        if (!op_wr_r) begin
                            rdata_r <= mem_r[addr_r];
                        end
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (!req_active_s) begin
                        state_r <= ST_IDLE;
                        ack_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                    cnt_r   <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_resp.sv
// Directed self-checking bench for mem_resp: a LAT=2 instance (u2) and a
// LAT=0 instance (u0) share clock and reset. Inputs change and outputs are
// sampled on the falling edge.
module tb_mem_resp;

    logic        clk;
    logic        rst_f;
    logic        rd2, wr2, ack2, busy2, err2;
    logic [7:0]  addr2;
    logic [31:0] wdata2, rdata2;
    logic        rd0, wr0, ack0, busy0, err0;
    logic [7:0]  addr0;
    logic [31:0] wdata0, rdata0;

    int checks;
    int failures;

    mem_resp #(.DW(32), .AW(8), .LAT(2)) u2 (
        .clk(clk), .rst_f(rst_f), .req_rd(rd2), .req_wr(wr2),
        .req_addr(addr2), .req_wdata(wdata2), .ack(ack2), .rdata(rdata2),
        .busy(busy2), .err(err2)
    );

    mem_resp #(.DW(32), .AW(8), .LAT(0)) u0 (
        .clk(clk), .rst_f(rst_f), .req_rd(rd0), .req_wr(wr0),
        .req_addr(addr0), .req_wdata(wdata0), .ack(ack0), .rdata(rdata0),
        .busy(busy0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Complete a LAT=2 write (used for preloading known RAM contents).
    task automatic u2_write(input logic [7:0] a, input logic [31:0] d);
        wr2 = 1'b1; addr2 = a; wdata2 = d;
        tick(); tick(); tick();
        checks++; if (ack2 !== 1'b1) begin failures++; $display("FAIL preload_ack got=%0b exp=1", ack2); end
        wr2 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_f = 1'b0;
        rd2 = 1'b0; wr2 = 1'b0; addr2 = 8'h00; wdata2 = 32'h0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = 8'h00; wdata0 = 32'h0;
        tick(); tick();
        checks++; if ({ack2, busy2, err2} !== 3'b000) begin failures++; $display("FAIL reset_ctl2 got=%03b exp=000", {ack2, busy2, err2}); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
        checks++; if ({ack0, busy0, err0} !== 3'b000) begin failures++; $display("FAIL reset_ctl0 got=%03b exp=000", {ack0, busy0, err0}); end
        rst_f = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        wr2 = 1'b1; addr2 = 8'h10; wdata2 = 32'hDEADBEEF;
        tick();
        checks++; if ({busy2, ack2} !== 2'b10) begin failures++; $display("FAIL wr_e0 busy_ack got=%02b exp=10", {busy2, ack2}); end
        tick();
        checks++; if ({busy2, ack2} !== 2'b10) begin failures++; $display("FAIL wr_e1 busy_ack got=%02b exp=10", {busy2, ack2}); end
        tick();
        checks++; if ({busy2, ack2} !== 2'b01) begin failures++; $display("FAIL wr_e2 busy_ack got=%02b exp=01", {busy2, ack2}); end
        checks++; if (rdata2 !== 32'h0) begin failures++; $display("FAIL wr_rdata_unchanged got=%h exp=0", rdata2); end
        wr2 = 1'b0;
        tick();
        checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL wr_drop_ack got=%0b exp=0", ack2); end
        rd2 = 1'b1; addr2 = 8'h10;
        tick();
        checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL rd_e0_busy got=%0b exp=1", busy2); end
        tick();
        checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL rd_e1_ack got=%0b exp=0", ack2); end
        tick();
        checks++; if (ack2 !== 1'b1) begin failures++; $display("FAIL rd_e2_ack got=%0b exp=1", ack2); end
        checks++; if (rdata2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", rdata2); end
        rd2 = 1'b0;
        tick();
        checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL rd_drop_ack got=%0b exp=0", ack2); end
        checks++; if (rdata2 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data_hold got=%h exp=deadbeef", rdata2); end
    endtask

    task automatic test_lat0();
        wr0 = 1'b1; addr0 = 8'h00; wdata0 = 32'hCAFEF00D;
        tick();
        checks++; if ({busy0, ack0} !== 2'b01) begin failures++; $display("FAIL lat0_wr busy_ack got=%02b exp=01", {busy0, ack0}); end
        wr0 = 1'b0;
        tick();
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL lat0_wr_drop got=%0b exp=0", ack0); end
        rst_f = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();
        rd0 = 1'b1; addr0 = 8'h00;
        tick();
        checks++; if ({busy0, ack0} !== 2'b01) begin failures++; $display("FAIL lat0_rd busy_ack got=%02b exp=01", {busy0, ack0}); end
        checks++; if (rdata0 !== 32'hCAFEF00D) begin failures++; $display("FAIL lat0_rd_data got=%h exp=cafef00d", rdata0); end
        rd0 = 1'b0;
        tick();
        checks++; if (ack0 !== 1'b0) begin failures++; $display("FAIL lat0_rd_drop got=%0b exp=0", ack0); end
    endtask

    task automatic test_abort();
        u2_write(8'h20, 32'h5555AAAA);
        wr2 = 1'b1; addr2 = 8'h20; wdata2 = 32'h00001234;
        tick();
        checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL abort_busy got=%0b exp=1", busy2); end
        wr2 = 1'b0;
        tick();
        checks++; if ({busy2, ack2} !== 2'b00) begin failures++; $display("FAIL abort_idle busy_ack got=%02b exp=00", {busy2, ack2}); end
        tick();
        checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL abort_noack got=%0b exp=0", ack2); end
        rd2 = 1'b1; addr2 = 8'h20;
        tick(); tick(); tick();
        checks++; if (rdata2 !== 32'h5555AAAA || ack2 !== 1'b1) begin failures++; $display("FAIL abort_readback got=%h/%0b exp=5555aaaa/1", rdata2, ack2); end
        rd2 = 1'b0;
        tick();
    endtask

    task automatic test_protocol_err();
        rd2 = 1'b1; wr2 = 1'b1; addr2 = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if ({err2, ack2, busy2} !== 3'b100) begin failures++; $display("FAIL perr_cyc%0d err_ack_busy got=%03b exp=100", i, {err2, ack2, busy2}); end
        end
        wr2 = 1'b0;
        tick();
        checks++; if ({err2, busy2} !== 2'b01) begin failures++; $display("FAIL perr_accept err_busy got=%02b exp=01", {err2, busy2}); end
        tick(); tick();
        checks++; if ({err2, ack2} !== 2'b01 || rdata2 !== 32'hDEADBEEF) begin failures++; $display("FAIL perr_complete got=%02b/%h exp=01/deadbeef", {err2, ack2}, rdata2); end
        rd2 = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        u2_write(8'h30, 32'h11112222);
        wr2 = 1'b1; addr2 = 8'h30; wdata2 = 32'h99999999;
        tick();
        checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL areset_busy_pre got=%0b exp=1", busy2); end
        #2 rst_f = 1'b0;
        #1;
        checks++; if ({ack2, busy2} !== 2'b00 || rdata2 !== 32'h0) begin failures++; $display("FAIL areset_immediate got=%02b/%h exp=00/0", {ack2, busy2}, rdata2); end
        tick();
        wr2 = 1'b0;
        tick();
        rst_f = 1'b1;
        tick();
        rd2 = 1'b1; addr2 = 8'h30;
        tick();
        checks++; if (busy2 !== 1'b1) begin failures++; $display("FAIL areset_after_busy got=%0b exp=1", busy2); end
        tick(); tick();
        checks++; if (ack2 !== 1'b1 || rdata2 !== 32'h11112222) begin failures++; $display("FAIL areset_readback got=%0b/%h exp=1/11112222", ack2, rdata2); end
        rd2 = 1'b0;
        tick();
    endtask

    task automatic test_held();
        u2_write(8'h44, 32'hA5A5A5A5);
        rd2 = 1'b1; addr2 = 8'h44;
        tick(); tick(); tick();
        checks++; if (ack2 !== 1'b1 || rdata2 !== 32'hA5A5A5A5) begin failures++; $display("FAIL held_first got=%0b/%h exp=1/a5a5a5a5", ack2, rdata2); end
        // A second access would pick up the new data here if it happened.
        wr2 = 1'b0; addr2 = 8'h10;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if ({ack2, busy2} !== 2'b10 || rdata2 !== 32'hA5A5A5A5) begin failures++; $display("FAIL held_cyc%0d got=%02b/%h exp=10/a5a5a5a5", i, {ack2, busy2}, rdata2); end
        end
        rd2 = 1'b0;
        tick();
        checks++; if (ack2 !== 1'b0) begin failures++; $display("FAIL held_drop got=%0b exp=0", ack2); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_lat0();
        test_abort();
        test_protocol_err();
        test_async_reset();
        test_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Data-memory responder for the SISC core: serves the load/store requests the control FSM issues during its mem state.
- Four-phase req/ack handshake, a programmable number of wait states, and an internal word-addressed RAM.
- Sits between the control/datapath and storage. The control FSM stalls in mem until ack is seen.

Parameters:
- DW, 32, data word width.
- AW, 8, address width; RAM depth is 2**AW words.
- LAT, 2, wait-state count. Range 0..15. ack rises exactly LAT clock edges after the accept edge.

Ports:
- clk  in  1  clock, rising edge.
- rst_f  in  1  reset, asynchronous, active-low.
- req_rd  in  1  read request, held high until ack seen.
- req_wr  in  1  write request, held high until ack seen.
- req_addr  in  AW  word address, sampled at accept.
- req_wdata  in  DW  write data, sampled at accept.
- ack  out  1  access complete; held while the request is still high.
- rdata  out  DW  read data; valid while ack=1 for a read, held until the next read completes.
- busy  out  1  request accepted and not yet acked.
- err  out  1  protocol error: req_rd and req_wr both high in IDLE.

Behaviour:
- Reset (rst_f low, async): state=IDLE, ack=0, busy=0, err=0, rdata=0, wait counter=0. RAM contents are not cleared.
- Reset mid-operation aborts the access. A pending write is not performed.
- States: IDLE, WAIT, RESP. All outputs are registered.
- IDLE, accept (exactly one of req_rd/req_wr high at a rising edge):
  - latch op, addr and wdata;
  - busy<=1.
  - If LAT==0, go directly to RESP and perform the access on this edge.
  - Otherwise go to WAIT with cnt<=LAT.
- IDLE, both requests high: no access; state stays IDLE; err<=1. err stays registered high on every edge where both are high in IDLE, and is 0 otherwise.
- IDLE, neither request high: no change.
- WAIT:
  - If the active request drops (abort): go to IDLE, busy<=0, no access, no ack.
  - Else if cnt==1: go to RESP and perform the access on this edge.
  - Else cnt<=cnt-1.
  - Changes on req_addr/req_wdata during WAIT are ignored (latched values are used).
- Access on entry to RESP:
  - write: RAM[addr]<=wdata; rdata unchanged.
  - read: rdata<=RAM[addr].
  - ack<=1, busy<=0.
- RESP:
  - ack stays 1 while the latched request is high.
  - On the first edge that samples it low: go to IDLE, ack<=0.
  - A new request cannot be accepted before the return to IDLE, so the minimum gap between accepts is LAT+2 edges.
- Latency: accept edge E0, ack visible after edge E0+LAT; read data is valid in the same cycle as ack.
- Address wrap: addresses are AW bits, so no out-of-range case exists.
- Read after write to the same address returns the written value (the write completes before RESP is exited).

Test Plan:
- Write then read, LAT=2:
  - req_wr, addr=8'h10, wdata=32'hDEADBEEF, accepted at E0 -> busy=1 after E0, ack=1 after E2, busy=0.
  - Drop req -> ack=0 one edge later.
  - req_rd, addr=8'h10 -> rdata=32'hDEADBEEF with ack after E0+2.
- LAT=0 instance: req_rd, addr=8'h00 after reset -> ack=1 after the accept edge; busy never seen high in a sampled cycle; rdata equals the preloaded RAM[0].
- Abort: req_wr, addr=8'h20, wdata=32'h1234 accepted; req_wr dropped after 1 WAIT cycle -> returns to IDLE, ack never 1; a later read of 8'h20 returns the prior value.
- Protocol error: req_rd=req_wr=1 for 3 cycles in IDLE -> err=1 for those 3 cycles, no ack, busy=0; then req_rd alone -> normal completion with err=0.
- Async reset during WAIT of a write to 8'h30 -> ack=0, busy=0, rdata=0 immediately; a later read of 8'h30 returns the pre-write value; after rst_f rises, the next request is served normally.
- Held request: keep req_rd high 5 cycles past ack -> ack stays 1 throughout, no second access, rdata stable; ack falls one edge after req_rd falls.
